// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder
// Description : Rate-1/2 feed-forward convolutional encoder, one bit/handshake.
//               CONV_ENC_TAIL_EN adds K-1 zero tail pairs per frame.
// Revision    : 1.0
// ============================================================================

module conv_encoder #(
    parameter int unsigned    K     = 3,
    parameter logic [K-1:0]   G0    = 3'b111,
    parameter logic [K-1:0]   G1    = 3'b101,
    parameter int unsigned    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       out_pair,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_bits
);

    localparam int unsigned SR_W = K - 1;

`ifdef CONV_ENC_TAIL_EN
    localparam int unsigned     TC_W    = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    logic [TC_W-1:0] tc_q, tc_d;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d, sr_shift;
    logic [1:0]       pair_q, pair_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_free;
    logic             in_xfer;
    logic             tail_emit;
    logic             new_pair;
    logic             enc_bit;
    logic [K-1:0]     v;

    assign out_free = !valid_q || out_ready;
    assign in_ready = ((state_q == S_IDLE) || (state_q == S_DATA)) && out_free;
    assign in_xfer  = in_valid && in_ready;
`ifdef CONV_ENC_TAIL_EN
    assign tail_emit = (state_q == S_TAIL) && out_free;
`else
    assign tail_emit = 1'b0;
`endif
    assign new_pair = in_xfer || tail_emit;
    // Tail slots encode a forced zero input.
    assign enc_bit  = in_xfer && in_bit;
    assign v        = {enc_bit, sr_q};

    generate
        if (K == 2) begin : g_sr_k2
            assign sr_shift = enc_bit;
        end else begin : g_sr_kn
            assign sr_shift = {enc_bit, sr_q[SR_W-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        pair_d  = pair_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef CONV_ENC_TAIL_EN
        tc_d    = tc_q;
`endif

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (new_pair) begin
            valid_d = 1'b1;
            last_d  = 1'b0;
            pair_d  = {^(v & G0), ^(v & G1)};
            sr_d    = sr_shift;
        end

        if (in_xfer) begin
            if (state_q == S_IDLE) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = S_DATA;
            if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                state_d = S_TAIL;
                tc_d    = '0;
`else
                // Truncated trellis: next frame starts from state 0.
                state_d = S_IDLE;
                last_d  = 1'b1;
                sr_d    = '0;
`endif
            end
        end

`ifdef CONV_ENC_TAIL_EN
        if (tail_emit) begin
            if (tc_q == TC_LAST) begin
                last_d  = 1'b1;
                state_d = S_IDLE;
                tc_d    = '0;
            end else begin
                tc_d = tc_q + TC_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef CONV_ENC_TAIL_EN
            tc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            pair_q  <= pair_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef CONV_ENC_TAIL_EN
            tc_q    <= tc_d;
`endif
        end
    end

    assign out_pair   = pair_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign frame_bits = cnt_q;
    assign busy       = (state_q != S_IDLE) || valid_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder
// Description : Self-checking bench for conv_encoder (honours CONV_ENC_TAIL_EN).
// Revision    : 1.0
// ============================================================================

module tb_conv_encoder;

    localparam int unsigned  K     = 3;
    localparam logic [K-1:0] TG0   = 3'b111;
    localparam logic [K-1:0] TG1   = 3'b101;
    localparam int unsigned  CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_bit, in_valid, in_last, in_ready;
    logic [1:0]       out_pair;
    logic             out_valid, out_last, out_ready, busy;
    logic [CNT_W-1:0] frame_bits;

    conv_encoder #(.K(K), .G0(TG0), .G1(TG1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_pair(out_pair), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frame_bits(frame_bits)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame-local convolution ----------------
    typedef struct {
        logic [1:0] pair;
        logic       last;
    } exp_t;

    exp_t q[$];
    bit   hist[$];
    int   frames_sent = 0;
    int   lasts_seen  = 0;

    // Output for the newest bit in hist: sum over taps of g[K-1-j] * u[n-j], bits before frame start are 0.
    function automatic logic [1:0] model_pair();
        int   n;
        logic p0, p1, u;
        n  = hist.size();
        p0 = 1'b0;
        p1 = 1'b0;
        for (int j = 0; j < int'(K); j++) begin
            u  = (n - 1 - j >= 0) ? hist[n-1-j] : 1'b0;
            p0 = p0 ^ (TG0[K-1-j] & u);
            p1 = p1 ^ (TG1[K-1-j] & u);
        end
        return {p0, p1};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            hist.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_pair", {30'd0, out_pair}, {30'd0, e.pair});
                    check("sb_last", {31'd0, out_last}, {31'd0, e.last});
                end
                if (out_last) lasts_seen++;
            end
            if (in_valid && in_ready) begin
                hist.push_back(in_bit);
`ifdef CONV_ENC_TAIL_EN
                q.push_back('{model_pair(), 1'b0});
`else
                q.push_back('{model_pair(), in_last});
`endif
                if (in_last) begin
                    frames_sent++;
`ifdef CONV_ENC_TAIL_EN
                    for (int t = 0; t < int'(K) - 1; t++) begin
                        hist.push_back(1'b0);
                        q.push_back('{model_pair(), (t == int'(K) - 2)});
                    end
`endif
                    hist.delete();
                end
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic       v, b, l, r;
        logic       ov;
        logic [1:0] pair;
        logic       last;
        logic       bsy;
        logic [15:0] fb;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic v, input logic b, input logic l, input logic r);
        in_valid  = v;
        in_bit    = b;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Frame 1,0,1,1 -> 11,10,00,01 (+ tail 01,11)
`ifdef CONV_ENC_TAIL_EN
        tbl.push_back('{1,1,0,1, 1,2'b11,0,1, 16'd1});
        tbl.push_back('{1,0,0,1, 1,2'b10,0,1, 16'd2});
        tbl.push_back('{1,1,0,1, 1,2'b00,0,1, 16'd3});
        tbl.push_back('{1,1,1,1, 1,2'b01,0,1, 16'd4});
        tbl.push_back('{0,0,0,1, 1,2'b01,0,1, 16'd4});
        tbl.push_back('{0,0,0,1, 1,2'b11,1,1, 16'd4});
        tbl.push_back('{0,0,0,1, 0,2'b11,0,0, 16'd4});
        // One-bit frame: 11, 10, 11(last)
        tbl.push_back('{1,1,1,1, 1,2'b11,0,1, 16'd1});
        tbl.push_back('{0,0,0,1, 1,2'b10,0,1, 16'd1});
        tbl.push_back('{0,0,0,1, 1,2'b11,1,1, 16'd1});
        tbl.push_back('{0,0,0,1, 0,2'b11,0,0, 16'd1});
`else
        tbl.push_back('{1,1,0,1, 1,2'b11,0,1, 16'd1});
        tbl.push_back('{1,0,0,1, 1,2'b10,0,1, 16'd2});
        tbl.push_back('{1,1,0,1, 1,2'b00,0,1, 16'd3});
        tbl.push_back('{1,1,1,1, 1,2'b01,1,1, 16'd4});
        // Next frame bit 1 -> 11 only if the trellis was cleared
        tbl.push_back('{1,1,1,1, 1,2'b11,1,1, 16'd1});
        tbl.push_back('{0,0,0,1, 0,2'b11,0,0, 16'd1});
`endif

        do_reset();
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_out_pair",   {30'd0, out_pair},  32'd0);
        check("rst_out_last",   {31'd0, out_last},  32'd0);
        check("rst_busy",       {31'd0, busy},      32'd0);
        check("rst_frame_bits", {16'd0, frame_bits}, 32'd0);
        check("rst_in_ready",   {31'd0, in_ready},  32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].r);
            check("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].ov});
            if (tbl[i].ov) check("tbl_out_pair", {30'd0, out_pair}, {30'd0, tbl[i].pair});
            check("tbl_out_last", {31'd0, out_last}, {31'd0, tbl[i].last});
            check("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].bsy});
            check("tbl_frame_bits", {16'd0, frame_bits}, {16'd0, tbl[i].fb});
        end

        // Backpressure: pair 11 pending, out_ready low for 3 cycles.
        do_reset();
        drive(1, 1, 0, 0);
        in_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            drive(1, 0, 0, 0);
            check("bp_pair_hold", {30'd0, out_pair}, 32'd3);
            check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        drive(1, 0, 0, 1);
        check("bp_release_pair", {30'd0, out_pair}, 32'd2);
        drive(1, 1, 0, 1);
        check("bp_pair3", {30'd0, out_pair}, 32'd0);
        drive(1, 1, 1, 1);
        check("bp_pair4", {30'd0, out_pair}, 32'd1);
        repeat (6) drive(0, 0, 0, 1);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a frame (during the first tail pair if tail is enabled).
        do_reset();
`ifdef CONV_ENC_TAIL_EN
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 1);
        check("mid_tail_pair", {30'd0, out_pair}, 32'd2);
`else
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 1);
`endif
        rst = 1'b1;
        drive(0, 0, 0, 1);
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        drive(1, 0, 0, 1);
        check("midrst_pair", {30'd0, out_pair}, 32'd0);
        drive(0, 0, 0, 1);

        // Random back-to-back frames, in_valid always high.
        do_reset();
        frames_sent = 0;
        lasts_seen  = 0;
        for (int c = 0; c < 1500; c++) begin
            drive(1'b1, 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 12; c++) drive(0, 0, 0, 1);
        check("rand_queue_empty", q.size(), 32'd0);
        check("rand_last_per_frame", lasts_seen, frames_sent);
        check("rand_idle_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
